// File: rtl/ysyx_22040175_pipe_ctrl_pkg.sv
// Shared constants for the NPC pipeline hazard controller.
// Optional performance counters are built when YSYX_22040175_PIPE_PERF_EN is defined.
package ysyx_22040175_pipe_ctrl_pkg;

  localparam int STG_IF   = 0;
  localparam int STG_ID   = 1;
  localparam int STG_EX   = 2;
  localparam int FWD_NONE = 0;
  localparam int DEF_AW   = 5;

  // Per-cycle pipeline action, listed from lowest to highest priority class
  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_LOAD_USE = 2'd1,
    HZ_REDIRECT = 2'd2,
    HZ_MEM      = 2'd3
  } hz_e;

endpackage

// File: rtl/ysyx_22040175_pipe_ctrl_if.sv
// ID-stage metadata, pipeline events and hazard controls between the core and the controller.
interface ysyx_22040175_pipe_ctrl_if #(
  parameter int AW     = ysyx_22040175_pipe_ctrl_pkg::DEF_AW,
  parameter int SW     = 3,
  parameter int NSTAGE = 5
);
  logic              id_valid;
  logic [AW-1:0]     id_rs1;
  logic              id_rs1_used;
  logic [AW-1:0]     id_rs2;
  logic              id_rs2_used;
  logic [AW-1:0]     id_rd;
  logic              id_wen;
  logic              id_is_load;
  logic              ex_redirect;
  logic              mem_stall;
  logic              stall_if;
  logic              stall_id;
  logic              flush_if;
  logic              flush_id;
  logic [SW-1:0]     fwd_rs1;
  logic [SW-1:0]     fwd_rs2;
  logic [NSTAGE-1:0] stage_valid;
  logic              retire;
  logic [AW-1:0]     retire_rd;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_wen, id_is_load,
           ex_redirect, mem_stall,
    input  stall_if, stall_id, flush_if, flush_id, fwd_rs1, fwd_rs2, stage_valid, retire, retire_rd
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_wen, id_is_load,
           ex_redirect, mem_stall,
    output stall_if, stall_id, flush_if, flush_id, fwd_rs1, fwd_rs2, stage_valid, retire, retire_rd
  );
endinterface

// File: rtl/ysyx_22040175_pipe_ctrl_stage_meta.sv
// One pipeline-stage slice of destination metadata {valid, wen, load, rd}.
// hold freezes the slice; clear loads an empty (bubble) entry instead of the upstream one.
module ysyx_22040175_stage_meta #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          clear,
  input  logic          valid_d,
  input  logic          wen_d,
  input  logic          load_d,
  input  logic [AW-1:0] rd_d,
  output logic          valid_q,
  output logic          wen_q,
  output logic          load_q,
  output logic [AW-1:0] rd_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      load_q  <= 1'b0;
      rd_q    <= '0;
    end else if (!hold) begin
      if (clear) begin
        valid_q <= 1'b0;
        wen_q   <= 1'b0;
        load_q  <= 1'b0;
        rd_q    <= '0;
      end else begin
        valid_q <= valid_d;
        wen_q   <= wen_d;
        load_q  <= load_d;
        rd_q    <= rd_d;
      end
    end
  end

endmodule

// File: rtl/ysyx_22040175_pipe_ctrl.sv
// Hazard controller for the in-order NPC: tracks EX..WB destinations, resolves load-use stalls,
// redirect flushes and forwarding selects. Define YSYX_22040175_PIPE_PERF_EN for perf counters.
module ysyx_22040175_pipe_ctrl
  import ysyx_22040175_pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int AW       = DEF_AW,
  parameter int LOAD_LAT = 1,
  parameter int SW       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_22040175_pipe_ctrl_if.slave bus
`ifdef YSYX_22040175_PIPE_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_flush_cnt,
  output logic [31:0]             perf_retire_cnt
`endif
);

  localparam int NM = NSTAGE - STG_EX;
  localparam int WB = NM - 1;

  logic          m_valid [NM];
  logic          m_wen   [NM];
  logic          m_load  [NM];
  logic [AW-1:0] m_rd    [NM];
  logic          d_valid [NM];
  logic          d_wen   [NM];
  logic          d_load  [NM];
  logic [AW-1:0] d_rd    [NM];

  logic          hit1 [NM];
  logic          hit2 [NM];
  logic          pend [NM];
  logic          load_use;
  logic          stall;
  logic          flush;
  logic          ex_bubble;
  logic          retire;
  logic [SW-1:0] fwd1;
  logic [SW-1:0] fwd2;
  logic [NSTAGE-1:0] sv;
  hz_e           hz;

  function automatic logic src_match(input logic v, input logic w, input logic [AW-1:0] rd,
                                     input logic [AW-1:0] r, input logic used);
    return v & w & used & (r != '0) & (rd == r);
  endfunction

  // ---- stage metadata chain: slice 0 is EX, slice WB is the last stage ----
  for (genvar i = 0; i < NM; i++) begin : g_stage
    if (i == 0) begin : g_ex
      assign d_valid[i] = bus.id_valid;
      assign d_wen[i]   = bus.id_wen;
      assign d_load[i]  = bus.id_is_load;
      assign d_rd[i]    = bus.id_rd;
    end else begin : g_adv
      assign d_valid[i] = m_valid[i-1];
      assign d_wen[i]   = m_wen[i-1];
      assign d_load[i]  = m_load[i-1];
      assign d_rd[i]    = m_rd[i-1];
    end

    ysyx_22040175_stage_meta #(.AW(AW)) u_meta (
      .clk     (clk),
      .rst     (rst),
      .hold    (bus.mem_stall),
      .clear   ((i == 0) && ex_bubble),
      .valid_d (d_valid[i]),
      .wen_d   (d_wen[i]),
      .load_d  (d_load[i]),
      .rd_d    (d_rd[i]),
      .valid_q (m_valid[i]),
      .wen_q   (m_wen[i]),
      .load_q  (m_load[i]),
      .rd_q    (m_rd[i])
    );
  end

  // ---- dependency check against in-flight producers ----
  always_comb begin
    load_use = 1'b0;
    fwd1     = SW'(FWD_NONE);
    fwd2     = SW'(FWD_NONE);
    for (int i = 0; i < NM; i++) begin
      hit1[i] = src_match(m_valid[i], m_wen[i], m_rd[i], bus.id_rs1, bus.id_rs1_used);
      hit2[i] = src_match(m_valid[i], m_wen[i], m_rd[i], bus.id_rs2, bus.id_rs2_used);
      pend[i] = m_load[i] && (i < LOAD_LAT);
    end
    // Walk oldest-to-youngest so the youngest eligible producer wins; WB goes via the regfile.
    for (int i = WB - 1; i >= 0; i--) begin
      if (hit1[i] && !pend[i]) fwd1 = SW'(i + STG_EX);
      if (hit2[i] && !pend[i]) fwd2 = SW'(i + STG_EX);
      if (pend[i] && (hit1[i] || hit2[i])) load_use = bus.id_valid;
    end
  end

  // ---- action priority: reset > memory freeze > redirect > load-use ----
  always_comb begin
    hz = HZ_NONE;
    if (!rst) begin
      if (bus.mem_stall)        hz = HZ_MEM;
      else if (bus.ex_redirect) hz = HZ_REDIRECT;
      else if (load_use)        hz = HZ_LOAD_USE;
    end
  end

  assign stall     = (hz == HZ_MEM) || (hz == HZ_LOAD_USE);
  assign flush     = (hz == HZ_REDIRECT);
  assign ex_bubble = flush || (hz == HZ_LOAD_USE);
  assign retire    = m_valid[WB] & ~bus.mem_stall;

  always_comb begin
    sv = '0;
    for (int i = 0; i < NM; i++) sv[i + STG_EX] = m_valid[i];
  end

  assign bus.stall_if    = stall;
  assign bus.stall_id    = stall;
  assign bus.flush_if    = flush;
  assign bus.flush_id    = flush;
  assign bus.fwd_rs1     = fwd1;
  assign bus.fwd_rs2     = fwd2;
  assign bus.stage_valid = sv;
  assign bus.retire      = retire;
  assign bus.retire_rd   = (retire && m_wen[WB]) ? m_rd[WB] : '0;

`ifdef YSYX_22040175_PIPE_PERF_EN
  // ---- event counters, free-running and wrapping ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_retire_cnt <= '0;
    end else begin
      if (stall)  perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      if (flush)  perf_flush_cnt  <= perf_flush_cnt + 32'd1;
      if (retire) perf_retire_cnt <= perf_retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040175_pipe_ctrl.sv
// Scoreboard bench for ysyx_22040175_pipe_ctrl: a 5-stage/LOAD_LAT=1 and a 7-stage/LOAD_LAT=2 instance
// driven in turn against an instruction-level pipeline model. Honours YSYX_22040175_PIPE_PERF_EN.
module tb_ysyx_22040175_pipe_ctrl;
  import ysyx_22040175_pipe_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int SW = 3;

  typedef struct {
    bit v, w, ld;
    int rd, rs1, rs2;
    bit u1, u2;
  } ins_t;

  typedef struct {
    int d;
    int si, sid, fi, fid, f1, f2, sv, ret, rrd, pst, pfl, prt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  ysyx_22040175_pipe_ctrl_if #(.AW(AW), .SW(SW), .NSTAGE(5)) bus_a ();
  ysyx_22040175_pipe_ctrl_if #(.AW(AW), .SW(SW), .NSTAGE(7)) bus_b ();

`ifdef YSYX_22040175_PIPE_PERF_EN
  logic [31:0] ps_a, pf_a, pr_a, ps_b, pf_b, pr_b;
`endif

  ysyx_22040175_pipe_ctrl #(.NSTAGE(5), .AW(AW), .LOAD_LAT(1), .SW(SW)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a)
`ifdef YSYX_22040175_PIPE_PERF_EN
    , .perf_stall_cnt (ps_a), .perf_flush_cnt (pf_a), .perf_retire_cnt (pr_a)
`endif
  );

  ysyx_22040175_pipe_ctrl #(.NSTAGE(7), .AW(AW), .LOAD_LAT(2), .SW(SW)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b)
`ifdef YSYX_22040175_PIPE_PERF_EN
    , .perf_stall_cnt (ps_b), .perf_flush_cnt (pf_b), .perf_retire_cnt (pr_b)
`endif
  );

  // Reference model: the instruction sitting in each stage, by stage index.
  ins_t pipe [8];
  int   ns = 5, ll = 1, cur = 0;
  int   cs = 0, cf = 0, cr = 0;
  bit   last_stall = 1'b0;
  exp_t q [$];
  exp_t me, mo, so;
  int   checks = 0, errors = 0;

  task automatic check(input int d, input string n, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL dut%0d %s: got %0d expected %0d at %0t", d, n, act, req, $time);
    end
  endtask

  function automatic ins_t mk(bit v, bit w, bit ld, int rd, int rs1, bit u1, int rs2, bit u2);
    ins_t i;
    i.v = v; i.w = w; i.ld = ld; i.rd = rd; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    bit w;
    w = ($urandom_range(0, 3) != 0);
    return mk($urandom_range(0, 7) != 0, w, w && ($urandom_range(0, 2) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
  endfunction

  // Producer in stage s writes architectural register r (x0 is never a real destination).
  function automatic bit writes(int s, int r);
    return pipe[s].v && pipe[s].w && r != 0 && pipe[s].rd == r;
  endfunction

  // A load whose data is not yet available for forwarding.
  function automatic bit pending(int s);
    return pipe[s].ld && (s < STG_EX + ll);
  endfunction

  function automatic int fwd_of(int r, bit used);
    if (!used) return 0;
    for (int s = STG_EX; s <= ns - 2; s++)
      if (writes(s, r) && !pending(s)) return s;
    return 0;
  endfunction

  task automatic drive(input ins_t id, input bit red, input bit ms, input bit r);
    if (cur == 0) begin
      rst_a = r;
      bus_a.id_valid = id.v;  bus_a.id_wen = id.w;  bus_a.id_is_load = id.ld;
      bus_a.id_rd = AW'(id.rd);  bus_a.id_rs1 = AW'(id.rs1);  bus_a.id_rs2 = AW'(id.rs2);
      bus_a.id_rs1_used = id.u1;  bus_a.id_rs2_used = id.u2;
      bus_a.ex_redirect = red;  bus_a.mem_stall = ms;
    end else begin
      rst_b = r;
      bus_b.id_valid = id.v;  bus_b.id_wen = id.w;  bus_b.id_is_load = id.ld;
      bus_b.id_rd = AW'(id.rd);  bus_b.id_rs1 = AW'(id.rs1);  bus_b.id_rs2 = AW'(id.rs2);
      bus_b.id_rs1_used = id.u1;  bus_b.id_rs2_used = id.u2;
      bus_b.ex_redirect = red;  bus_b.mem_stall = ms;
    end
  endtask

  function automatic exp_t sample(int d);
    exp_t o;
    o = '{default: 0};
    o.d = d;
    if (d == 0) begin
      o.si = int'(bus_a.stall_if);  o.sid = int'(bus_a.stall_id);
      o.fi = int'(bus_a.flush_if);  o.fid = int'(bus_a.flush_id);
      o.f1 = int'(bus_a.fwd_rs1);   o.f2 = int'(bus_a.fwd_rs2);
      o.sv = int'(bus_a.stage_valid);
      o.ret = int'(bus_a.retire);   o.rrd = int'(bus_a.retire_rd);
`ifdef YSYX_22040175_PIPE_PERF_EN
      o.pst = int'(ps_a); o.pfl = int'(pf_a); o.prt = int'(pr_a);
`endif
    end else begin
      o.si = int'(bus_b.stall_if);  o.sid = int'(bus_b.stall_id);
      o.fi = int'(bus_b.flush_if);  o.fid = int'(bus_b.flush_id);
      o.f1 = int'(bus_b.fwd_rs1);   o.f2 = int'(bus_b.fwd_rs2);
      o.sv = int'(bus_b.stage_valid);
      o.ret = int'(bus_b.retire);   o.rrd = int'(bus_b.retire_rd);
`ifdef YSYX_22040175_PIPE_PERF_EN
      o.pst = int'(ps_b); o.pfl = int'(pf_b); o.prt = int'(pr_b);
`endif
    end
    return o;
  endfunction

  // One clock of stimulus: apply inputs, predict the response, then advance the model.
  task automatic step(input ins_t id, input bit red, input bit ms, input bit r);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    drive(id, red, ms, r);
    e = '{default: 0};
    e.d = cur;
    if (r) begin
      foreach (pipe[s]) pipe[s] = '{default: 0};
      cs = 0; cf = 0; cr = 0;
      last_stall = 1'b0;
    end else begin
      lu = 1'b0;
      for (int s = STG_EX; s < STG_EX + ll; s++)
        if (pending(s) && ((id.u1 && writes(s, id.rs1)) || (id.u2 && writes(s, id.rs2))))
          lu = id.v;
      e.fid = int'(red && !ms);
      e.fi  = e.fid;
      e.sid = int'(ms || (lu && e.fid == 0));
      e.si  = e.sid;
      e.f1  = fwd_of(id.rs1, id.u1);
      e.f2  = fwd_of(id.rs2, id.u2);
      for (int s = STG_EX; s < ns; s++) if (pipe[s].v) e.sv |= (1 << s);
      e.ret = int'(pipe[ns-1].v && !ms);
      e.rrd = (e.ret != 0 && pipe[ns-1].w) ? pipe[ns-1].rd : 0;
      e.pst = cs; e.pfl = cf; e.prt = cr;
      cs += e.sid; cf += e.fid; cr += e.ret;
      if (!ms) begin
        for (int s = ns - 1; s > STG_EX; s--) pipe[s] = pipe[s-1];
        if (id.v && e.sid == 0 && e.fid == 0) pipe[STG_EX] = id;
        else pipe[STG_EX] = '{default: 0};
      end
      last_stall = (e.sid != 0);
    end
    q.push_back(e);
  endtask

  // Present one instruction in ID until the controller lets it into EX.
  task automatic issue(input ins_t id, output int n);
    n = 0;
    do begin
      step(id, 1'b0, 1'b0, 1'b0);
      n++;
    end while (last_stall && n < 16);
    if (last_stall) check(cur, "issue_timeout", n, 0);
  endtask

  task automatic run_random(input int cycles, input bit with_rst);
    ins_t id;
    bit   r;
    id = rand_ins();
    for (int k = 0; k < cycles; k++) begin
      r = with_rst && ($urandom_range(0, 59) == 0);
      step(id, $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, r);
      if (r || !last_stall) id = rand_ins();
    end
  endtask

  // Monitor: compare every predicted cycle against the DUT on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        me = q.pop_front();
        mo = sample(me.d);
        check(me.d, "stall_if",    mo.si,  me.si);
        check(me.d, "stall_id",    mo.sid, me.sid);
        check(me.d, "flush_if",    mo.fi,  me.fi);
        check(me.d, "flush_id",    mo.fid, me.fid);
        check(me.d, "fwd_rs1",     mo.f1,  me.f1);
        check(me.d, "fwd_rs2",     mo.f2,  me.f2);
        check(me.d, "stage_valid", mo.sv,  me.sv);
        check(me.d, "retire",      mo.ret, me.ret);
        if (me.ret != 0) check(me.d, "retire_rd", mo.rrd, me.rrd);
`ifdef YSYX_22040175_PIPE_PERF_EN
        check(me.d, "perf_stall",  mo.pst, me.pst);
        check(me.d, "perf_flush",  mo.pfl, me.pfl);
        check(me.d, "perf_retire", mo.prt, me.prt);
`endif
      end
    end
  end

  initial begin
    ins_t nop;
    int   n;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    cur = 1; drive(nop, 1'b0, 1'b0, 1'b1);
    cur = 0; drive(nop, 1'b0, 1'b0, 1'b1);

    // ---------------- NSTAGE=5, LOAD_LAT=1 ----------------
    ns = 5; ll = 1;
    step(nop, 1'b0, 1'b0, 1'b1);
    step(nop, 1'b1, 1'b1, 1'b1);
    step(nop, 1'b0, 1'b0, 1'b0);

    // add x5 then add x6,x5: forward from EX without stalling
    issue(mk(1, 1, 0, 5, 0, 0, 0, 0), n);
    issue(mk(1, 1, 0, 6, 5, 1, 0, 0), n);
    #1; so = sample(0);
    check(0, "t1_fwd_rs1", so.f1, 2);
    check(0, "t1_issue_cycles", n, 1);

    // lw x5 then add x6,x5: one stall cycle, then forward from MEM
    issue(mk(1, 1, 1, 5, 0, 0, 0, 0), n);
    issue(mk(1, 1, 0, 6, 0, 0, 5, 1), n);
    #1; so = sample(0);
    check(0, "t2_fwd_rs2", so.f2, 3);
    check(0, "t2_issue_cycles", n, 2);

    // redirect while a load-use dependent sits in ID
    issue(mk(1, 1, 1, 5, 0, 0, 0, 0), n);
    step(mk(1, 1, 0, 6, 5, 1, 0, 0), 1'b1, 1'b0, 1'b0);
    #1; so = sample(0);
    check(0, "t3_flush_id", so.fid, 1);
    check(0, "t3_stall_id", so.sid, 0);
    step(nop, 1'b0, 1'b0, 1'b0);
    #1; so = sample(0);
    check(0, "t3_ex_valid", (so.sv >> 2) & 1, 0);

    // memory freeze with redirect pending, then release
    issue(mk(1, 1, 0, 1, 0, 0, 0, 0), n);
    issue(mk(1, 1, 0, 2, 1, 1, 0, 0), n);
    issue(mk(1, 1, 0, 3, 2, 1, 1, 1), n);
    repeat (3) step(mk(1, 0, 0, 0, 3, 1, 0, 0), 1'b1, 1'b1, 1'b0);
    #1; so = sample(0);
    check(0, "t4_frozen_flush", so.fid, 0);
    check(0, "t4_frozen_retire", so.ret, 0);
    step(mk(1, 0, 0, 0, 3, 1, 0, 0), 1'b1, 1'b0, 1'b0);
    #1; so = sample(0);
    check(0, "t4_release_flush", so.fid, 1);

    // x0 destinations never forward or stall
    issue(mk(1, 1, 0, 0, 0, 0, 0, 0), n);
    issue(mk(1, 1, 1, 0, 0, 0, 0, 0), n);
    issue(mk(1, 1, 0, 4, 0, 1, 0, 1), n);
    #1; so = sample(0);
    check(0, "t5_fwd_x0", so.f1, 0);
    check(0, "t5_issue_cycles", n, 1);
    repeat (4) step(nop, 1'b0, 1'b0, 1'b0);

    run_random(400, 1'b0);
    @(negedge clk);
    #1 rst_a = 1'b1;

    // ---------------- NSTAGE=7, LOAD_LAT=2 ----------------
    cur = 1; ns = 7; ll = 2;
    step(nop, 1'b0, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b0, 1'b0);
    issue(mk(1, 1, 1, 5, 0, 0, 0, 0), n);
    issue(mk(1, 1, 0, 6, 5, 1, 0, 0), n);
    #1; so = sample(1);
    check(1, "t6_fwd_rs1", so.f1, 4);
    check(1, "t6_issue_cycles", n, 3);

    // reset pulsed while frozen on a memory stall
    issue(mk(1, 1, 1, 2, 0, 0, 0, 0), n);
    issue(mk(1, 1, 0, 3, 0, 0, 0, 0), n);
    step(mk(1, 1, 0, 1, 2, 1, 0, 0), 1'b0, 1'b1, 1'b0);
    step(mk(1, 1, 0, 1, 2, 1, 0, 0), 1'b1, 1'b1, 1'b1);
    #1; so = sample(1);
    check(1, "t6_rst_stall_if", so.si, 0);
    check(1, "t6_rst_stage_valid", so.sv, 0);
`ifdef YSYX_22040175_PIPE_PERF_EN
    check(1, "t6_rst_perf_retire", so.prt, 0);
`endif
    step(nop, 1'b0, 1'b0, 1'b0);

    run_random(500, 1'b1);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) check(cur, "scoreboard_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
